psum_requant_acc: RTL and testbench

//  Multi-channel partial-sum combiner and requantiser for the conv output path. Adds N_CH signed

---
 rtl/psum_pkg.sv | 45 ++++
 rtl/psum_requant_acc_if.sv | 37 +++
 rtl/psum_requant.sv | 48 ++++
 rtl/psum_requant_acc.sv | 199 +++++++++++++++++++
 tb/tb_psum_requant_acc.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : psum_pkg                                                         |
// | Desc     : Shared widths, accumulator FSM state type and saturating clip    |
// |            helper for the partial-sum combiner / requantiser.               |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package psum_pkg;

   // Default widths of the conv output path
   localparam int unsigned c_n_ch   = 3;
   localparam int unsigned c_in_w   = 21;
   localparam int unsigned c_acc_w  = 26;
   localparam int unsigned c_out_w  = 8;
   localparam int unsigned c_pass_w = 4;
   localparam int unsigned c_cnt_w  = 16;

   // Wide signed working type, comfortably larger than any accumulator here
   localparam int unsigned c_calc_w = 64;
   typedef logic signed [c_calc_w-1:0] calc_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_e;

   // Clamp a wide signed value into the signed range of a w-bit number
   function automatic calc_t sat_clip(input calc_t v, input int unsigned w);
      calc_t hi;
      calc_t lo;
      hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
      lo = -(calc_t'(1) <<< (w - 1));
      if (v > hi) begin
         sat_clip = hi;
      end else if (v < lo) begin
         sat_clip = lo;
      end else begin
         sat_clip = v;
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/psum_requant_acc_if.sv
// +----------------------------------------------------------------------------+
// | Module   : psum_requant_acc_if                                              |
// | Desc     : Input beat and output activation valid/ready streams of the      |
// |            partial-sum combiner. slave = design view, master = environment. |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface psum_requant_acc_if
   import psum_pkg::*;
#(
   parameter int unsigned N_CH  = c_n_ch,
   parameter int unsigned IN_W  = c_in_w,
   parameter int unsigned OUT_W = c_out_w
) ();

   logic                    in_vld;
   logic                    in_rdy;
   logic [N_CH*IN_W-1:0]    in_data;
   logic                    out_vld;
   logic                    out_rdy;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_sat;

   modport slave (
      input  in_vld, in_data, out_rdy,
      output in_rdy, out_vld, out_data, out_sat
   );

   modport master (
      output in_vld, in_data, out_rdy,
      input  in_rdy, out_vld, out_data, out_sat
   );

endinterface

`default_nettype wire

// File: rtl/psum_requant.sv
// +----------------------------------------------------------------------------+
// | Module   : psum_requant                                                     |
// | Desc     : Combinational arithmetic right shift of the accumulator with     |
// |            saturation to a signed OUT_W activation.                         |
// |            PSUM_ROUND_EN defined   : round-half-up before the shift.        |
// |            PSUM_ROUND_EN undefined : truncation (floor).                    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module psum_requant
   import psum_pkg::*;
#(
   parameter int unsigned ACC_W = c_acc_w,
   parameter int unsigned OUT_W = c_out_w
) (
   input  logic signed [ACC_W-1:0] acc_i,
   input  logic        [4:0]       shift_i,
   output logic signed [OUT_W-1:0] data_o,
   output logic                    sat_o
);

   calc_t wide;
   calc_t biased;
   calc_t shifted;
   calc_t clipped;

   // Bias (optional), shift, then clip; shifts past ACC_W leave only sign bits
   always_comb begin
      wide = calc_t'(acc_i);
`ifdef PSUM_ROUND_EN
      if (shift_i == 5'd0) begin
         biased = wide;
      end else begin
         biased = sat_clip(wide + (calc_t'(1) <<< (shift_i - 5'd1)), ACC_W);
      end
`else
      biased = wide;
`endif
      shifted = biased >>> shift_i;
      clipped = sat_clip(shifted, OUT_W);
      data_o  = OUT_W'(clipped);
      sat_o   = (clipped != shifted);
   end

endmodule

`default_nettype wire

// File: rtl/psum_requant_acc.sv
// +----------------------------------------------------------------------------+
// | Module   : psum_requant_acc                                                 |
// | Desc     : Adds N_CH signed partial sums per beat, accumulates cfg_passes   |
// |            beats, requantises (shift + saturate) to OUT_W. Pipeline:        |
// |            S1 channel sum, S2 accumulator FSM, S3 output register.          |
// |            Rounding mode selected by macro PSUM_ROUND_EN (see psum_requant).|
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module psum_requant_acc
   import psum_pkg::*;
#(
   parameter int unsigned N_CH   = c_n_ch,
   parameter int unsigned IN_W   = c_in_w,
   parameter int unsigned ACC_W  = c_acc_w,
   parameter int unsigned OUT_W  = c_out_w,
   parameter int unsigned PASS_W = c_pass_w,
   parameter int unsigned CNT_W  = c_cnt_w
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   psum_requant_acc_if.slave bus,
   input  logic [PASS_W-1:0] cfg_passes,
   input  logic [4:0]        cfg_shift,
   output logic [CNT_W-1:0]  sat_cnt,
   output logic              busy
);

   logic stall;
   logic accept;

   // S1
   logic signed [ACC_W-1:0] ch_ext [N_CH];
   logic signed [ACC_W-1:0] sum_d;
   logic                    s1_vld_q;
   logic signed [ACC_W-1:0] s1_sum_q;
   logic [PASS_W-1:0]       s1_passes_q;
   logic [4:0]              s1_shift_q;

   // S2
   acc_state_e              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [PASS_W-1:0]       pass_cnt_q, pass_cnt_d;
   logic [PASS_W-1:0]       passes_q, passes_d;
   logic [4:0]              shift_q, shift_d;
   logic                    s2_vld_q, s2_vld_d;
   logic [PASS_W-1:0]       passes_eff;

   // S3
   logic                    out_vld_q;
   logic signed [OUT_W-1:0] out_data_q;
   logic                    out_sat_q;
   logic [CNT_W-1:0]        sat_cnt_q;
   logic signed [OUT_W-1:0] rq_data;
   logic                    rq_sat;

   // A held output freezes the whole pipeline; clr also blocks new beats
   assign stall      = out_vld_q && !bus.out_rdy;
   assign bus.in_rdy = !stall && !clr;
   assign accept     = bus.in_vld && bus.in_rdy;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch_ext
      assign ch_ext[g] = ACC_W'($signed(bus.in_data[g*IN_W +: IN_W]));
   end

   // Sum of all channels of the incoming beat
   always_comb begin
      sum_d = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         sum_d = sum_d + ch_ext[c];
      end
   end

   // S1: register the beat sum together with the configuration seen at accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q    <= 1'b0;
         s1_sum_q    <= '0;
         s1_passes_q <= '0;
         s1_shift_q  <= '0;
      end else if (clr) begin
         s1_vld_q    <= 1'b0;
      end else if (!stall) begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_sum_q    <= sum_d;
            s1_passes_q <= cfg_passes;
            s1_shift_q  <= cfg_shift;
         end
      end
   end

   assign passes_eff = (s1_passes_q == '0) ? PASS_W'(1) : s1_passes_q;

   // S2 next state: first beat latches config, later beats accumulate with saturation
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      pass_cnt_d = pass_cnt_q;
      passes_d   = passes_q;
      shift_d    = shift_q;
      s2_vld_d   = s2_vld_q;
      if (!stall) begin
         s2_vld_d = 1'b0;
         if (s1_vld_q) begin
            case (state_q)
               IDLE: begin
                  acc_d      = s1_sum_q;
                  pass_cnt_d = PASS_W'(1);
                  passes_d   = passes_eff;
                  shift_d    = s1_shift_q;
                  if (passes_eff == PASS_W'(1)) begin
                     s2_vld_d = 1'b1;
                  end else begin
                     state_d = ACCUM;
                  end
               end
               ACCUM: begin
                  acc_d      = ACC_W'(sat_clip(calc_t'(acc_q) + calc_t'(s1_sum_q), ACC_W));
                  pass_cnt_d = pass_cnt_q + PASS_W'(1);
                  if (pass_cnt_d == passes_q) begin
                     s2_vld_d = 1'b1;
                     state_d  = IDLE;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // S2 state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         pass_cnt_q <= '0;
         passes_q   <= '0;
         shift_q    <= '0;
         s2_vld_q   <= 1'b0;
      end else if (clr) begin
         state_q    <= IDLE;
         pass_cnt_q <= '0;
         s2_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         pass_cnt_q <= pass_cnt_d;
         passes_q   <= passes_d;
         shift_q    <= shift_d;
         s2_vld_q   <= s2_vld_d;
      end
   end

   psum_requant #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_requant (
      .acc_i   (acc_q),
      .shift_i (shift_q),
      .data_o  (rq_data),
      .sat_o   (rq_sat)
   );

   // S3: output register and sticky clip counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
         sat_cnt_q  <= '0;
      end else if (clr) begin
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
         sat_cnt_q  <= '0;
      end else if (!stall) begin
         out_vld_q <= s2_vld_q;
         if (s2_vld_q) begin
            out_data_q <= rq_data;
            out_sat_q  <= rq_sat;
            if (rq_sat && (sat_cnt_q != '1)) begin
               sat_cnt_q <= sat_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign bus.out_vld  = out_vld_q;
   assign bus.out_data = out_data_q;
   assign bus.out_sat  = out_sat_q;
   assign sat_cnt      = sat_cnt_q;
   assign busy         = (state_q != IDLE) || s1_vld_q || s2_vld_q || out_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_psum_requant_acc.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_psum_requant_acc                                              |
// | Desc     : Scoreboard bench for psum_requant_acc. Expected outputs are      |
// |            queued when final beats are driven and popped on each accepted   |
// |            output. Rounding expectations follow PSUM_ROUND_EN.              |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_psum_requant_acc;

   localparam int IN_W = 21;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  cfg_passes;
   logic [4:0]  cfg_shift;
   logic [15:0] sat_cnt;
   logic        busy;

   int     n_checks = 0;
   int     n_errors = 0;
   int     n_out = 0;
   int     exp_sat_cnt = 0;
   bit     rand_rdy = 1'b0;
   longint exp_d_q[$];
   bit     exp_s_q[$];
   longint mon_d;
   bit     mon_s;

   always #5 clk = ~clk;

   psum_requant_acc_if #(.N_CH(3), .IN_W(IN_W), .OUT_W(8)) bus ();

   psum_requant_acc dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .bus        (bus),
      .cfg_passes (cfg_passes),
      .cfg_shift  (cfg_shift),
      .sat_cnt    (sat_cnt),
      .busy       (busy)
   );

   task automatic check_val(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic expect_out(input longint d, input bit s);
      exp_d_q.push_back(d);
      exp_s_q.push_back(s);
      if (s) exp_sat_cnt++;
   endtask

   // Reference requantiser: sum of one group -> (data, clipped)
   task automatic model(input longint sum, input int sh, output longint d, output bit s);
      longint r;
      r = sum;
`ifdef PSUM_ROUND_EN
      if (sh > 0) r = r + (longint'(1) << (sh - 1));
`endif
      r = r >>> sh;
      if (r > 127) begin
         d = 127; s = 1'b1;
      end else if (r < -128) begin
         d = -128; s = 1'b1;
      end else begin
         d = r; s = 1'b0;
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Drive one beat; called and returns at posedge+1
   task automatic send(input int a, input int b, input int c);
      bit ok;
      ok = 1'b0;
      bus.in_data = {IN_W'(c), IN_W'(b), IN_W'(a)};
      bus.in_vld  = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.in_rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_val("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.in_vld = 1'b0;
   endtask

   // Wait until every expected output has been seen and the pipeline is empty
   task automatic wait_idle(input int max_cyc);
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge clk);
         if (exp_d_q.size() == 0 && !busy) return;
      end
      check_val("drain_timeout", exp_d_q.size(), 0);
   endtask

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && bus.out_vld && bus.out_rdy) begin
         n_out++;
         if (exp_d_q.size() == 0) begin
            check_val("unexpected_out", bus.out_data, 9999);
         end else begin
            mon_d = exp_d_q.pop_front();
            mon_s = exp_s_q.pop_front();
            check_val("out_data", longint'(bus.out_data), mon_d);
            check_val("out_sat", bus.out_sat, longint'(mon_s));
         end
      end
   end

   // Random output backpressure
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         bus.out_rdy = ($urandom_range(0, 1) == 1);
      end
   end

   initial begin
      int     lat;
      int     n0;
      int     a, b, c;
      longint ed;
      bit     es;
      bus.in_vld  = 1'b0;
      bus.in_data = '0;
      bus.out_rdy = 1'b1;
      cfg_passes  = 4'd1;
      cfg_shift   = 5'd8;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_out_vld", bus.out_vld, 0);
      check_val("rst_out_data", longint'(bus.out_data), 0);
      check_val("rst_out_sat", bus.out_sat, 0);
      check_val("rst_sat_cnt", sat_cnt, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_in_rdy", bus.in_rdy, 1);
      sync();

      // Basic sum and latency
      expect_out(6, 1'b0);
      send(256, 512, 768);
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus.out_vld) begin
            lat = k;
            break;
         end
      end
      check_val("t1_latency", lat, 3);
      wait_idle(50);
      sync();

      // Saturation both ways
      expect_out(127, 1'b1);
      send(20000, 20000, 20000);
      wait_idle(50);
      check_val("t2_sat_cnt1", sat_cnt, 1);
      sync();
      expect_out(-128, 1'b1);
      send(-20000, -20000, -20000);
      wait_idle(50);
      check_val("t2_sat_cnt2", sat_cnt, 2);
      sync();

      // Multi-pass; config change before the last beat must be ignored
      cfg_passes = 4'd3;
      cfg_shift  = 5'd0;
      n0 = n_out;
      send(1, 1, 1);
      send(1, 1, 1);
      repeat (6) @(negedge clk);
      check_val("t3_no_early", n_out - n0, 0);
      check_val("t3_busy", busy, 1);
      sync();
      cfg_passes = 4'd1;
      cfg_shift  = 5'd4;
      expect_out(9, 1'b0);
      send(1, 1, 1);
      wait_idle(50);
      check_val("t3_one_out", n_out - n0, 1);
      sync();

      // Held output under backpressure
      cfg_passes  = 4'd1;
      cfg_shift   = 5'd0;
      bus.out_rdy = 1'b0;
      expect_out(5, 1'b0);
      send(5, 0, 0);
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.out_vld) begin
            lat = 1;
            break;
         end
      end
      check_val("t4_out_vld_seen", lat, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("t4_hold_vld", bus.out_vld, 1);
         check_val("t4_hold_in_rdy", bus.in_rdy, 0);
         check_val("t4_hold_data", longint'(bus.out_data), 5);
      end
      sync();
      bus.out_rdy = 1'b1;
      wait_idle(50);
      sync();

      // Random backpressure over 32 single-pass beats
      cfg_shift = 5'd2;
      n0 = n_out;
      rand_rdy = 1'b1;
      for (int i = 0; i < 32; i++) begin
         a = int'($urandom_range(0, 400)) - 200;
         b = int'($urandom_range(0, 400)) - 200;
         c = int'($urandom_range(0, 400)) - 200;
         model(longint'(a + b + c), 2, ed, es);
         expect_out(ed, es);
         send(a, b, c);
      end
      wait_idle(800);
      rand_rdy = 1'b0;
      bus.out_rdy = 1'b1;
      check_val("t4_rand_count", n_out - n0, 32);
      check_val("t4_rand_sat_cnt", sat_cnt, exp_sat_cnt);
      sync();

      // Rounding mode
      cfg_shift = 5'd8;
`ifdef PSUM_ROUND_EN
      expect_out(2, 1'b0);
`else
      expect_out(1, 1'b0);
`endif
      send(384, 0, 0);
`ifdef PSUM_ROUND_EN
      expect_out(-1, 1'b0);
`else
      expect_out(-2, 1'b0);
`endif
      send(-384, 0, 0);
      wait_idle(50);
      sync();

      // Abort a partial group with clr
      cfg_passes = 4'd3;
      cfg_shift  = 5'd0;
      n0 = n_out;
      send(7, 0, 0);
      send(7, 0, 0);
      clr = 1'b1;
      @(negedge clk);
      check_val("t6_clr_in_rdy", bus.in_rdy, 0);
      sync();
      clr = 1'b0;
      exp_sat_cnt = 0;
      repeat (6) @(negedge clk);
      check_val("t6_no_out", n_out - n0, 0);
      check_val("t6_busy", busy, 0);
      check_val("t6_sat_cnt", sat_cnt, 0);
      sync();
      send(2, 0, 0);
      send(2, 0, 0);
      expect_out(6, 1'b0);
      send(2, 0, 0);
      wait_idle(50);
      sync();

      // Asynchronous reset mid-group
      send(2, 0, 0);
      check_val("t6_busy_pre_rst", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_arst_out_vld", bus.out_vld, 0);
      check_val("t6_arst_out_data", longint'(bus.out_data), 0);
      check_val("t6_arst_out_sat", bus.out_sat, 0);
      check_val("t6_arst_busy", busy, 0);
      check_val("t6_arst_sat_cnt", sat_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
